// File: rtl/conj_mult_arbiter.sv
// Two-requester arbiter feeding a 2-stage pipelined complex multiplier computing a*conj(b).
// Round-robin or fixed-priority grant; the whole pipeline stalls as a unit under output backpressure.
module conj_mult_arbiter #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 2*WIDTH+1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s0_valid,
  output logic                        s0_ready,
  input  logic signed [WIDTH-1:0]     s0_a_real,
  input  logic signed [WIDTH-1:0]     s0_a_imag,
  input  logic signed [WIDTH-1:0]     s0_b_real,
  input  logic signed [WIDTH-1:0]     s0_b_imag,
  input  logic                        s1_valid,
  output logic                        s1_ready,
  input  logic signed [WIDTH-1:0]     s1_a_real,
  input  logic signed [WIDTH-1:0]     s1_a_imag,
  input  logic signed [WIDTH-1:0]     s1_b_real,
  input  logic signed [WIDTH-1:0]     s1_b_imag,
  input  logic                        prio_mode,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_tag,
  output logic signed [OUT_WIDTH-1:0] m_real,
  output logic signed [OUT_WIDTH-1:0] m_imag
);

  localparam int PW = 2*WIDTH;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_e;

  req_e                        last_grant;
  req_e                        gnt;
  logic                        gnt_any;
  logic                        advance;

  logic                        st1_vld;
  req_e                        st1_tag;
  logic signed [PW-1:0]        st1_rr, st1_ii, st1_ir, st1_ri;

  logic                        st2_vld;
  req_e                        st2_tag;
  logic signed [OUT_WIDTH-1:0] st2_re, st2_im;

  logic signed [WIDTH-1:0]     sel_ar, sel_ai, sel_br, sel_bi;
  logic signed [PW-1:0]        x_ar, x_ai, x_br, x_bi;
  logic signed [OUT_WIDTH-1:0] e_rr, e_ii, e_ir, e_ri;

  // Arbitration depends only on request inputs, mode, pointer and stage-2 state,
  // so m_ready reaches the readies but never m_valid.
  always_comb begin
    advance = !st2_vld || m_ready;
    gnt_any = 1'b0;
    gnt     = REQ0;
    if (advance) begin
      if (s0_valid && s1_valid) begin
        gnt_any = 1'b1;
        if (prio_mode)
          gnt = REQ0;
        else
          gnt = (last_grant == REQ0) ? REQ1 : REQ0;
      end else if (s0_valid) begin
        gnt_any = 1'b1;
        gnt     = REQ0;
      end else if (s1_valid) begin
        gnt_any = 1'b1;
        gnt     = REQ1;
      end
    end
    s0_ready = rst_n && gnt_any && (gnt == REQ0);
    s1_ready = rst_n && gnt_any && (gnt == REQ1);
  end

  always_comb begin
    sel_ar = (gnt == REQ1) ? s1_a_real : s0_a_real;
    sel_ai = (gnt == REQ1) ? s1_a_imag : s0_a_imag;
    sel_br = (gnt == REQ1) ? s1_b_real : s0_b_real;
    sel_bi = (gnt == REQ1) ? s1_b_imag : s0_b_imag;
    x_ar   = {{WIDTH{sel_ar[WIDTH-1]}}, sel_ar};
    x_ai   = {{WIDTH{sel_ai[WIDTH-1]}}, sel_ai};
    x_br   = {{WIDTH{sel_br[WIDTH-1]}}, sel_br};
    x_bi   = {{WIDTH{sel_bi[WIDTH-1]}}, sel_bi};
  end

  // One extra bit over the products keeps (-2^(W-1))^2 * 2 exact.
  always_comb begin
    e_rr = {{(OUT_WIDTH-PW){st1_rr[PW-1]}}, st1_rr};
    e_ii = {{(OUT_WIDTH-PW){st1_ii[PW-1]}}, st1_ii};
    e_ir = {{(OUT_WIDTH-PW){st1_ir[PW-1]}}, st1_ir};
    e_ri = {{(OUT_WIDTH-PW){st1_ri[PW-1]}}, st1_ri};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ1;
      st1_vld    <= 1'b0;
      st1_tag    <= REQ0;
      st1_rr     <= '0;
      st1_ii     <= '0;
      st1_ir     <= '0;
      st1_ri     <= '0;
      st2_vld    <= 1'b0;
      st2_tag    <= REQ0;
      st2_re     <= '0;
      st2_im     <= '0;
    end else if (advance) begin
      if (gnt_any)
        last_grant <= gnt;
      st1_vld <= gnt_any;
      st1_tag <= gnt;
      st1_rr  <= x_ar * x_br;
      st1_ii  <= x_ai * x_bi;
      st1_ir  <= x_ai * x_br;
      st1_ri  <= x_ar * x_bi;
      st2_vld <= st1_vld;
      st2_tag <= st1_tag;
      st2_re  <= e_rr + e_ii;
      st2_im  <= e_ir - e_ri;
    end
  end

  assign m_valid = st2_vld;
  assign m_tag   = st2_tag;
  assign m_real  = st2_re;
  assign m_imag  = st2_im;

endmodule

// File: tb/tb_conj_mult_arbiter.sv
// Randomized bench for conj_mult_arbiter against a queue-based model of accepted transfers,
// plus directed sequences with literal expectations.
module tb_conj_mult_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s0_valid = 1'b0, s1_valid = 1'b0, prio_mode = 1'b0, m_ready = 1'b0;
  logic s0_ready, s1_ready, m_valid, m_tag;
  logic signed [15:0] ar [2];
  logic signed [15:0] ai [2];
  logic signed [15:0] br [2];
  logic signed [15:0] bi [2];
  logic signed [32:0] m_real, m_imag;

  always #5 clk = ~clk;

  conj_mult_arbiter #(.WIDTH(16), .OUT_WIDTH(33)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s0_a_real(ar[0]), .s0_a_imag(ai[0]), .s0_b_real(br[0]), .s0_b_imag(bi[0]),
    .s1_valid(s1_valid), .s1_ready(s1_ready),
    .s1_a_real(ar[1]), .s1_a_imag(ai[1]), .s1_b_real(br[1]), .s1_b_imag(bi[1]),
    .prio_mode(prio_mode),
    .m_valid(m_valid), .m_ready(m_ready), .m_tag(m_tag),
    .m_real(m_real), .m_imag(m_imag)
  );

  // Each accepted transfer is an entry; 'age' counts pipeline-advancing edges since acceptance.
  typedef struct {
    int     age;
    bit     tag;
    longint re;
    longint im;
  } ent_t;

  ent_t q[$];
  bit   lg = 1'b1;
  int   n_chk = 0, n_err = 0;

  bit              rec_r0, rec_r1, rec_mv, rec_tag;
  logic signed [32:0] rec_real;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint cre(input int k);
    return longint'(ar[k]) * longint'(br[k]) + longint'(ai[k]) * longint'(bi[k]);
  endfunction

  function automatic longint cim(input int k);
    return longint'(ai[k]) * longint'(br[k]) - longint'(ar[k]) * longint'(bi[k]);
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input bit v0, input bit v1, input bit pm, input bit mr);
    bit   exp_mv, adv, g_any, g;
    ent_t e;
    s0_valid  = v0;
    s1_valid  = v1;
    prio_mode = pm;
    m_ready   = mr;
    #2;
    exp_mv = (q.size() > 0) && (q[0].age >= 2);
    adv    = !exp_mv || mr;
    g_any  = 1'b0;
    g      = 1'b0;
    if (adv) begin
      if (v0 && v1) begin g_any = 1'b1; g = pm ? 1'b0 : !lg; end
      else if (v0)  begin g_any = 1'b1; g = 1'b0; end
      else if (v1)  begin g_any = 1'b1; g = 1'b1; end
    end
    chk("s0_ready", s0_ready, g_any && !g);
    chk("s1_ready", s1_ready, g_any && g);
    chk("m_valid", m_valid, exp_mv);
    if (exp_mv) begin
      chk("m_real", m_real, q[0].re);
      chk("m_imag", m_imag, q[0].im);
      chk("m_tag", m_tag, q[0].tag);
    end
    rec_r0 = s0_ready; rec_r1 = s1_ready; rec_mv = m_valid; rec_tag = m_tag; rec_real = m_real;
    if (g_any) begin
      e.age = 0; e.tag = g; e.re = cre(g); e.im = cim(g);
    end
    @(posedge clk);
    if (adv) begin
      if (exp_mv) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (g_any) begin
        e.age = 1;
        q.push_back(e);
        lg = g;
      end
    end
    #1;
  endtask

  task automatic set_data(input int k, input int a_r, input int a_i, input int b_r, input int b_i);
    ar[k] = 16'(a_r); ai[k] = 16'(a_i); br[k] = 16'(b_r); bi[k] = 16'(b_i);
  endtask

  task automatic rand_data();
    for (int k = 0; k < 2; k++)
      set_data(k, int'($urandom), int'($urandom), int'($urandom), int'($urandom));
    if ($urandom_range(0, 9) == 0) set_data(int'($urandom_range(0, 1)), -32768, -32768, -32768, -32768);
  endtask

  // Called at posedge+1 with requests active, so ready must be forced low by reset.
  task automatic do_reset();
    s0_valid = 1'b1; s1_valid = 1'b1; m_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s0_ready", s0_ready, 0);
    chk("rst_s1_ready", s1_ready, 0);
    chk("rst_m_real", m_real, 0);
    chk("rst_m_imag", m_imag, 0);
    chk("rst_m_tag", m_tag, 0);
    q.delete();
    lg = 1'b1;
    @(posedge clk);
    @(posedge clk);
    s0_valid = 1'b0; s1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, nres;
    longint got [4];
    for (int k = 0; k < 2; k++) set_data(k, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    do_reset();

    // a=(3,4), b=(1,2) from s0
    set_data(0, 3, 4, 1, 2);
    step(1, 0, 0, 1);
    chk("basic_grant", rec_r0, 1);
    step(0, 0, 0, 1);
    chk("basic_mv", m_valid, 1);
    chk("basic_real", m_real, 11);
    chk("basic_imag", m_imag, -2);
    chk("basic_tag", m_tag, 0);

    // extreme operands from s1
    set_data(1, -32768, -32768, -32768, -32768);
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    chk("ext_real", m_real, 64'sd2147483648);
    chk("ext_imag", m_imag, 0);
    chk("ext_tag", m_tag, 1);
    step(0, 0, 0, 1);

    // round-robin after reset: 0,1,0,1,0,1 and tags two cycles later
    do_reset();
    set_data(0, 1, 2, 3, 4);
    set_data(1, 5, 6, 7, 8);
    for (int i = 0; i < 8; i++) begin
      step(i < 6, i < 6, 0, 1);
      if (i < 6) chk("rr_grant", rec_r0, (i % 2) == 0);
      if (i >= 2) begin
        chk("rr_out_valid", rec_mv, 1);
        chk("rr_out_tag", rec_tag, (i - 2) % 2);
      end
    end

    // fixed priority, then s0 drops
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 1);
      chk("fix_s0_ready", rec_r0, 1);
      chk("fix_s1_ready", rec_r1, 0);
    end
    step(0, 1, 1, 1);
    chk("fix_s1_alone", rec_r1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // backpressure: 4 transfers with results 1..4, m_ready low for 3 cycles after first result
    acc = 0; nres = 0;
    for (int i = 0; i < 14; i++) begin
      set_data(0, acc + 1, 0, 1, 0);
      step(acc < 4, 0, 0, !(i >= 2 && i <= 4));
      if (rec_r0) acc++;
      if (i >= 2 && i <= 4) begin
        chk("bp_stall_ready", rec_r0, 0);
        chk("bp_stall_hold", rec_real, 1);
      end
      if (rec_mv && m_ready && nres < 4) begin
        got[nres] = rec_real;
        nres++;
      end
    end
    chk("bp_count", nres, 4);
    for (int i = 0; i < 4; i++) chk("bp_order", got[i], i + 1);

    // reset with two results in flight
    set_data(0, 9, 9, 9, 9);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      chk("post_rst_no_stale", rec_mv, 0);
    end
    step(1, 1, 0, 1);
    chk("post_rst_first_grant", rec_r0, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_data();
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    end

    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    chk("drain_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/conj_mult_arbiter.md
CONJ_MULT_ARBITER -- requirements
Module: conj_mult_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signed input component width (two's complement).
REQ-002 SHALL have parameter OUT_WIDTH, default 2*WIDTH+1, result component width (full precision, no rounding or saturation).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports s0_valid, s1_valid  input  1  requester k offers an operand pair.
REQ-006 SHALL have ports s0_ready, s1_ready  output  1  requester k's pair is accepted this cycle.
REQ-007 SHALL have ports sK_a_real, sK_a_imag, sK_b_real, sK_b_imag (K=0,1)  input  WIDTH signed  operands a and b.
REQ-008 SHALL have port prio_mode  input  1  0 = round-robin, 1 = fixed priority to requester 0.
REQ-009 SHALL have ports m_valid (output, 1), m_ready (input, 1) and m_tag (output, 1), where m_tag is the index of the requester that produced the current result.
REQ-010 SHALL have ports m_real, m_imag  output  OUT_WIDTH signed  result a*conj(b).

Function
REQ-011 SHALL compute m_real = a_r*b_r + a_i*b_i and m_imag = a_i*b_r - a_r*b_i, sign-extended before addition, exact for all inputs including -2^(WIDTH-1).
REQ-012 SHALL implement a 2-stage pipeline: S1 registers the four products plus tag/valid; S2 registers the sum, difference, tag and valid, and drives m_*.
REQ-013 SHALL define advance = !S2.valid || m_ready; when advance=0, S1 and S2 hold all contents unchanged.
REQ-014 SHALL accept a transfer from requester k only when sK_valid && sK_ready; at most one sK_ready is high per cycle, and both are low when advance=0.
REQ-015 SHALL make sK_ready a combinational function of s0_valid, s1_valid, prio_mode, the last-grant pointer and advance; no combinational path from m_ready to m_valid is permitted.
REQ-016 SHALL, with exactly one requester valid and advance=1, grant that requester regardless of mode.
REQ-017 SHALL, in round-robin mode with both valid, grant the requester not granted at the last accepted transfer; the last_grant pointer updates only on an accepted transfer.
REQ-018 SHALL, in fixed mode with both valid, grant requester 0; last_grant still updates on each accepted transfer.
REQ-019 SHALL support a change of prio_mode on any cycle, taking effect in the same cycle's arbitration.
REQ-020 SHALL, when nothing is accepted while advance=1, load a bubble (valid=0) into S1.
REQ-021 SHALL produce the result of a transfer accepted in cycle N on m_* in cycle N+2 when no stall occurs, and one cycle later for each stalled cycle.
REQ-022 SHALL sustain throughput of one transfer per cycle while m_ready=1.
REQ-023 SHALL hold m_real, m_imag and m_tag stable while m_valid=1 && m_ready=0.
REQ-024 SHALL deliver results in acceptance order with the correct tag; no result may be dropped or duplicated.
REQ-025 SHALL NOT require requesters to hold sK_valid; a requester that deasserts sK_valid before a grant is simply not served.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force S1.valid=0, S2.valid=0, m_valid=0, m_tag=0, m_real=0, m_imag=0, s0_ready=0, s1_ready=0, and last_grant=1 so that requester 0 wins the first contention.
REQ-027 SHALL discard all in-flight data on reset asserted mid-operation; no result for those transfers appears after release.
REQ-028 SHALL allow s0_ready/s1_ready to assert in the first cycle after rst_n deasserts.

Verification
REQ-029 Basic: s0 sends a=(3,4), b=(1,2) at cycle N with m_ready=1 -> m_valid at N+2 with m_real=11, m_imag=-2, m_tag=0.
REQ-030 Extreme: s1 sends a=(-32768,-32768), b=(-32768,-32768) -> m_real=2147483648, m_imag=0, m_tag=1, with no overflow in the 33-bit output.
REQ-031 Round-robin: both requesters valid for 6 cycles, prio_mode=0, m_ready=1 -> grants in order 0,1,0,1,0,1 and output tags in the same order two cycles later.
REQ-032 Fixed priority: both valid, prio_mode=1 -> s0_ready=1 and s1_ready=0 every cycle; drop s0_valid -> s1 is granted in the same cycle.
REQ-033 Backpressure: stream of 4 transfers with m_ready=0 for 3 cycles after the first result -> m_* stays stable, s*_ready=0 while the pipeline is full, and all 4 results arrive in order once m_ready=1.
REQ-034 Reset mid-stream: assert rst_n=0 with 2 results in flight -> m_valid=0 immediately; after release, no stale result appears and the first contention grants requester 0.
